if_stage: RTL and testbench

Instruction-fetch stage placed directly upstream of the ID stage. It owns the program counter, issues requests to instruction memory through a valid/ready request channel and an in-order response channel, and buffers returned words in a 2-entry fetch queue. The head of the queue drives ID with `if_valid`, `if_instruction` and `if_pc`. ID may stall the stage, and ID (branch/jump) or the CSR/trap logic may redirect it, which flushes all wrong-path work.

---
 rtl/if_stage.sv | 202 ++++++++++++++++++++
 tb/tb_if_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`timescale 1ns/1ps
// ============================================================================
// if_stage
// ----------------------------------------------------------------------------
// Instruction-fetch stage that sits in front of ID. It owns the fetch PC and
// sends requests to instruction memory over a valid/ready request channel.
// Responses come back in order. Returned words wait in a 2-entry fetch queue,
// and the head of that queue is presented to ID. A redirect (branch, jump or
// trap) restarts fetch at a new PC and throws away all wrong-path work. That
// includes responses that are still in flight, which are counted and dropped
// when they arrive.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   imem_req_valid    : out, fetch request valid
//   imem_req_ready    : in,  memory accepts the request this cycle
//   imem_req_addr     : out, word-aligned fetch address (the fetch PC)
//   imem_resp_valid   : in,  response word valid (in request order)
//   imem_resp_data    : in,  returned instruction word
//   redirect_valid    : in,  restart fetch at redirect_pc (highest priority)
//   redirect_pc       : in,  new fetch PC; low two bits are ignored
//   stall             : in,  ID cannot take the head instruction this cycle
//   if_valid          : out, queue head valid
//   if_instruction    : out, head word, NOP when if_valid=0
//   if_pc             : out, head PC, 0 when if_valid=0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } mode_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    mode_t       r_mode, w_mode_next;
    logic [31:0] r_fetch_pc, w_fetch_pc_next;

    // Fetch queue: entry 0 is the head.
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic [31:0] w_q_pc_next    [2];
    logic [31:0] w_q_instr_next [2];
    logic [1:0]  r_q_cnt, w_q_cnt_next;

    // In-flight PC FIFO. It holds only live requests. Requests that are
    // still pending drop are counted in r_inflight but have no entry here.
    logic [31:0] r_fl_pc [2];
    logic [31:0] w_fl_pc_next [2];
    logic [1:0]  r_inflight, w_inflight_next;
    logic [1:0]  r_drop_cnt, w_drop_next;

    // ------------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------------
    logic        w_pop;
    logic        w_resp_eff;
    logic        w_resp_drop;
    logic        w_resp_live;
    logic        w_accept;
    logic [2:0]  w_occ;
    logic [1:0]  w_live_cnt;
    logic [1:0]  w_live_after_pop;
    logic [1:0]  w_q_after_pop;
    logic        w_q_wr_idx;
    logic        w_fl_wr_idx;
    logic [31:0] w_redirect_aligned;

    assign if_valid       = (r_q_cnt != 2'd0);
    assign if_instruction = if_valid ? r_q_instr[0] : NOP;
    assign if_pc          = if_valid ? r_q_pc[0]    : 32'h0;
    assign imem_req_addr  = r_fetch_pc;

    assign w_pop       = if_valid & ~stall;
    // A response with nothing outstanding belongs to a request issued
    // before the last reset, so it is ignored.
    assign w_resp_eff  = imem_resp_valid & (r_inflight != 2'd0);
    assign w_resp_drop = w_resp_eff & (r_drop_cnt != 2'd0);
    assign w_resp_live = w_resp_eff & (r_drop_cnt == 2'd0);

    // Occupancy at the end of this cycle, before any new request. Keeping
    // this below 2 reserves a queue slot for every live response, so the
    // queue can never overflow.
    assign w_occ = {1'b0, r_inflight} + {1'b0, r_q_cnt}
                 - {2'b00, w_pop} - {2'b00, w_resp_drop};

    assign imem_req_valid = (r_mode == RUN) & ~redirect_valid & (w_occ < 3'd2);
    assign w_accept       = imem_req_valid & imem_req_ready;

    assign w_live_cnt         = r_inflight - r_drop_cnt;
    assign w_live_after_pop   = w_live_cnt - {1'b0, w_resp_live};
    assign w_q_after_pop      = r_q_cnt - {1'b0, w_pop};
    assign w_q_wr_idx         = (w_q_after_pop != 2'd0);
    assign w_fl_wr_idx        = (w_live_after_pop != 2'd0);
    assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // ------------------------------------------------------------------------
    // Mode FSM: BOOT holds off fetch for one cycle after reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            BOOT: w_mode_next = RUN;
            RUN:  w_mode_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default on entry, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        w_q_pc_next     = r_q_pc;
        w_q_instr_next  = r_q_instr;
        w_q_cnt_next    = r_q_cnt;
        w_fl_pc_next    = r_fl_pc;
        w_inflight_next = r_inflight;
        w_drop_next     = r_drop_cnt;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle's response (which
            // is discarded whatever it is) belongs to the old path.
            w_fetch_pc_next = w_redirect_aligned;
            w_q_cnt_next    = 2'd0;
            w_inflight_next = r_inflight - {1'b0, w_resp_eff};
            w_drop_next     = r_inflight - {1'b0, w_resp_eff};
        end else begin
            // Fetch queue: shift out the head, then append the live response.
            if (w_pop) begin
                w_q_pc_next[0]    = r_q_pc[1];
                w_q_instr_next[0] = r_q_instr[1];
            end
            if (w_resp_live) begin
                w_q_pc_next[w_q_wr_idx]    = r_fl_pc[0];
                w_q_instr_next[w_q_wr_idx] = imem_resp_data;
            end
            w_q_cnt_next = w_q_after_pop + {1'b0, w_resp_live};

            // In-flight PC FIFO: the live response consumes the oldest PC,
            // and an accepted request appends the current fetch PC.
            if (w_resp_live) begin
                w_fl_pc_next[0] = r_fl_pc[1];
            end
            if (w_accept) begin
                w_fl_pc_next[w_fl_wr_idx] = r_fetch_pc;
                w_fetch_pc_next           = r_fetch_pc + 32'd4;
            end

            w_inflight_next = r_inflight + {1'b0, w_accept} - {1'b0, w_resp_eff};
            w_drop_next     = r_drop_cnt - {1'b0, w_resp_drop};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= BOOT;
            r_fetch_pc <= RESET_PC;
            r_q_cnt    <= 2'd0;
            r_inflight <= 2'd0;
            r_drop_cnt <= 2'd0;
        end else begin
            r_mode     <= w_mode_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_q_cnt    <= w_q_cnt_next;
            r_inflight <= w_inflight_next;
            r_drop_cnt <= w_drop_next;
        end
    end

    // NOTE: the payload arrays have no reset. Their contents matter only
    // under a nonzero count, and the counts are reset above.
    always_ff @(posedge clk) begin
        r_q_pc    <= w_q_pc_next;
        r_q_instr <= w_q_instr_next;
        r_fl_pc   <= w_fl_pc_next;
    end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Self-checking bench for if_stage. A behavioural memory answers requests
// in order after a programmable latency. The instruction word is a fixed
// function of the address, so every delivered word can be checked against
// its PC.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model: accepted requests wait in pend; each answers no earlier
    // than `lat` cycles after acceptance, in order.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t pend[$];
    int    cyc = 0;
    int    lat = 1;

    always @(posedge clk) begin
        if (imem_resp_valid && pend.size() > 0) pend.delete(0);
        if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
        cyc++;
    end

    task automatic mem_drive();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
    endtask

    // Start of a cycle: wait for the falling edge, then present the memory
    // response. The caller then sets its inputs and samples #2 later.
    task automatic tick();
        @(negedge clk);
        mem_drive();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors, one per cycle from reset release, 1-cycle memory.
    // ------------------------------------------------------------------
    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic        seen_req;
        logic [31:0] exp_pc;
        int          n_seen;
        int          w;

        //            stall redir rpc          valid pc            req  addr
        vecs[0]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h100};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h104};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h100,    1'b1, 32'h108};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h104,    1'b1, 32'h10C};
        vecs[10] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h108,    1'b1, 32'h110};
        vecs[11] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h10C,    1'b1, 32'h114};
        // Redirect + same-cycle response + stall: the response is discarded.
        vecs[12] = '{1'b1, 1'b1, 32'h400A,   1'b1, 32'h110,    1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h4008};
        vecs[14] = '{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h400C};
        vecs[15] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h4008,   1'b1, 32'h4010};
        vecs[16] = '{1'b0, 1'b0, 32'h0,      1'b1, 32'h400C,   1'b1, 32'h4014};

        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset state
        repeat (2) tick();
        #2;
        check("reset if_valid", {31'b0, if_valid}, 32'd0);
        check("reset if_pc", if_pc, 32'h0);
        check("reset if_instruction", if_instruction, NOP);
        check("reset req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Table: reset release, steady fetch, stall, redirect
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 0) rst = 1'b0;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #2;
            check($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
            check($sformatf("row%0d if_instruction", i), if_instruction,
                  vecs[i].e_valid ? instr_of(vecs[i].e_pc) : NOP);
            check($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) check($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].e_addr);
        end

        // Sequence A: redirect while two requests are in flight
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            stall          = 1'b0;
            redirect_valid = 1'b0;
            if (pend.size() == 2 && !imem_resp_valid) begin
                found          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h2002;
            end
            #2;
            if (found) check("A redirect-cycle req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        check("A reached two in flight", {31'b0, found}, 32'd1);
        seen_req = 1'b0;
        exp_pc   = 32'h2000;
        n_seen   = 0;
        for (int i = 0; i < 20 && n_seen < 2; i++) begin
            tick();
            redirect_valid = 1'b0;
            #2;
            if (imem_req_valid && !seen_req) begin
                seen_req = 1'b1;
                check("A first new req_addr", imem_req_addr, 32'h2000);
            end
            if (if_valid) begin
                check("A if_pc", if_pc, exp_pc);
                check("A if_instruction", if_instruction, instr_of(exp_pc));
                exp_pc += 32'd4;
                n_seen++;
            end
        end
        check("A new-path words delivered", n_seen, 32'd2);

        // Sequence B: ready low, then 3-cycle memory
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h5000;
        #2;
        w = 0;
        while (pend.size() != 0 && w < 10) begin
            tick();
            redirect_valid = 1'b0;
            #2;
            check("B no old word", {31'b0, if_valid}, 32'd0);
            w++;
        end
        redirect_valid = 1'b0;
        check("B old responses drained", pend.size(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check("B req_valid while not ready", {31'b0, imem_req_valid}, 32'd1);
            check("B req_addr stable", imem_req_addr, 32'h5000);
        end
        tick();
        imem_req_ready = 1'b1;
        lat            = 3;
        #2;
        exp_pc = 32'h5000;
        n_seen = 0;
        for (int i = 0; i < 40 && n_seen < 6; i++) begin
            tick();
            #2;
            check("B outstanding <= 2", {31'b0, pend.size() <= 2}, 32'd1);
            if (if_valid) begin
                check("B if_pc in order", if_pc, exp_pc);
                check("B if_instruction", if_instruction, instr_of(exp_pc));
                exp_pc += 32'd4;
                n_seen++;
            end
        end
        check("B words delivered", n_seen, 32'd6);

        // Sequence D: reset with two requests in flight
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (pend.size() == 2) begin
                found = 1'b1;
                rst   = 1'b1;
            end
            #2;
        end
        check("D reached two in flight", {31'b0, found}, 32'd1);
        check("D async if_valid", {31'b0, if_valid}, 32'd0);
        check("D async if_pc", if_pc, 32'h0);
        check("D async if_instruction", if_instruction, NOP);
        check("D async req_valid", {31'b0, imem_req_valid}, 32'd0);
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #2;
        w = 0;
        while (pend.size() != 0 && w < 10) begin
            tick();
            #2;
            check("D late response ignored", {31'b0, if_valid}, 32'd0);
            w++;
        end
        check("D late responses drained", pend.size(), 32'd0);
        tick();
        #2;
        check("D restart req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("D restart req_addr", imem_req_addr, RESET_PC);
        tick();
        imem_req_ready = 1'b1;
        lat            = 1;
        #2;
        exp_pc = RESET_PC;
        n_seen = 0;
        for (int i = 0; i < 12 && n_seen < 4; i++) begin
            tick();
            #2;
            if (if_valid) begin
                check("D if_pc after reset", if_pc, exp_pc);
                check("D if_instruction after reset", if_instruction, instr_of(exp_pc));
                exp_pc += 32'd4;
                n_seen++;
            end
        end
        check("D words after reset", n_seen, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
